saturn_serial_tx_fifo: RTL
==========================

// Module: saturn_serial_tx_fifo
// PURPOSE
//   Parametrised async serial transmitter with an internal TX FIFO, for debug/trace output.
//   Configurable baud divisor, data width, parity and stop bits.
//   Producers push characters with a valid/ready handshake.
//   The block serialises them LSB-first on o_serial_tx, back-to-back, with no CPU-side busy-waiting.
// PARAMETERS
//   CLKS_PER_BIT  217  i_clk cycles per bit cell (>=2)
//   DATA_BITS     8    data bits per frame (5..8)
//   PARITY        0    0 = none, 1 = odd, 2 = even
//   STOP_BITS     1    stop bit cells (1 or 2)
//   FIFO_DEPTH    16   FIFO entries, power of 2 (>=2); FIFO_AW = log2(FIFO_DEPTH)
// PORTS
//   i_clk           in   1            single clock; all logic on posedge
//   i_reset_n       in   1            synchronous reset, active low
//   i_char_to_send  in   DATA_BITS    character to enqueue
//   i_char_valid    in   1            producer has a character
//   o_char_ready    out  1            FIFO can accept (= level != FIFO_DEPTH)
//   o_serial_tx     out  1            serial line, idle high
//   o_serial_busy   out  1            state != IDLE or FIFO level != 0
//   o_fifo_level    out  FIFO_AW+1    entries currently queued (0..FIFO_DEPTH)
// BEHAVIOUR
//   Reset (i_reset_n low at a posedge), applied the following cycle:
//     - o_serial_tx=1, FIFO flushed (level 0), o_char_ready=1, o_serial_busy=0, FSM=IDLE, counters 0.
//     - Reset mid-frame aborts the frame; the line is driven high on the next cycle.
//   Push: FIFO writes on a posedge with i_char_valid && o_char_ready; input is sampled on that edge.
//     - Valid while full is ignored, not lost silently: the producer must hold valid until ready.
//     - No combinational path from i_char_valid to o_char_ready.
//   Pop: FSM reads the FIFO head when in IDLE, or at the end of the last stop cell, with level != 0.
//   Same-cycle push and pop: level unchanged. Push into a full FIFO with a pop in the same cycle is
//     NOT accepted (ready depends on level only).
//   Pointers wrap modulo FIFO_DEPTH; level is tracked separately, so full and empty are unambiguous.
//   FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or -> START if FIFO not empty.
//     - IDLE:   tx=1. If level != 0: pop into shift reg, compute parity, go START, baud counter 0.
//     - START:  tx=0 for CLKS_PER_BIT cycles.
//     - DATA:   tx=shift[0], shift right each cell; bit counter runs 0..DATA_BITS-1.
//     - PARITY: only if PARITY != 0. tx = ^data (even) or ~^data (odd), over DATA_BITS bits.
//     - STOP:   tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At the final cycle, a non-empty FIFO pops
//               directly and goes START (zero idle gap); otherwise go IDLE.
//   Baud counter counts 0..CLKS_PER_BIT-1; a cell ends when it reaches CLKS_PER_BIT-1, then wraps to 0.
//   Latency: char pushed at edge k into empty FIFO with FSM IDLE -> pop at edge k+1 -> tx=0 after
//     edge k+1. Frame length = (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
//   o_serial_tx is a registered output (no glitches).
//   o_fifo_level and o_char_ready update the cycle after the push/pop edge.
// TESTING
//   1. CLKS_PER_BIT=4, 8N1, push 0x55 -> tx cells 0,1,0,1,0,1,0,1,0,1 (start, LSB-first, stop),
//      each 4 cycles; busy for 41 cycles after the push edge; then tx=1, busy=0.
//   2. PARITY=2, push 0x07 -> parity cell=1. PARITY=1, push 0x07 -> parity cell=0.
//      PARITY=2, push 0x00 -> parity cell=0. Frame = 11 cells.
//   3. FIFO_DEPTH=4, hold valid with 6 chars 0x41..0x46 -> ready drops at level 4; all 6 chars
//      transmitted in order; each stop cell is followed immediately by the next start cell.
//   4. Mid-stream, push exactly on a pop edge -> o_fifo_level unchanged. Scoreboard shows no drop/dup.
//   5. Assert i_reset_n=0 during the 3rd data bit with 2 chars queued -> next cycle tx=1, level=0,
//      ready=1, busy=0. A char pushed after reset is sent with correct framing.
//   6. DATA_BITS=7, STOP_BITS=2, PARITY=0, push 0x7F -> 0, seven 1 cells, two stop cells (10 cells).

Source files
------------

// File: rtl/saturn_serial_tx_fifo_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | saturn_serial_tx_fifo_if - producer handshake and serial line status     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface saturn_serial_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] char_to_send;
  logic                 char_valid;
  logic                 char_ready;
  logic                 serial_tx;
  logic                 serial_busy;
  logic [FIFO_AW:0]     fifo_level;

  modport master (
    output char_to_send, char_valid,
    input  char_ready, serial_tx, serial_busy, fifo_level
  );

  modport slave (
    input  char_to_send, char_valid,
    output char_ready, serial_tx, serial_busy, fifo_level
  );
endinterface
`default_nettype wire

// File: rtl/saturn_serial_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | saturn_serial_tx_fifo - FIFO-buffered async serial TX, LSB-first frames  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module saturn_serial_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  saturn_serial_tx_fifo_if.slave bus
);
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int BAUD_W  = $clog2(CLKS_PER_BIT);
  localparam int BIT_W   = $clog2(DATA_BITS);

  localparam logic [BAUD_W-1:0]  BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0]  BAUD_ONE   = BAUD_W'(1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]   BIT_ONE    = BIT_W'(1);
  localparam logic               STOP_LAST  = 1'(STOP_BITS - 1);
  localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   LVL_ONE    = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   LEVEL_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr;
  logic [FIFO_AW-1:0]   rd_ptr;
  logic [FIFO_AW:0]     level;
  logic [DATA_BITS-1:0] shift;
  logic                 parity_bit;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 stop_cnt;
  logic                 tx;

  logic                 push;
  logic                 pop;
  logic                 cell_end;
  logic                 last_stop;
  logic [DATA_BITS-1:0] head;

  assign head      = mem[rd_ptr];
  assign cell_end  = (baud_cnt == BAUD_LAST);
  assign last_stop = (state == S_STOP) && cell_end && (stop_cnt == STOP_LAST);
  assign push      = bus.char_valid && bus.char_ready;
  // Popping straight out of the last stop cycle keeps frames gap-free.
  assign pop       = (level != '0) && ((state == S_IDLE) || last_stop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.char_to_send;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      level <= level + LVL_ONE;
      else if (!push && pop) level <= level - LVL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tx         <= 1'b1;
      shift      <= '0;
      parity_bit <= 1'b0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
    end else if (pop) begin
      state      <= S_START;
      shift      <= head;
      parity_bit <= (PARITY == 2) ? ^head : ~^head;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      tx         <= 1'b0;
    end else begin
      if (state != S_IDLE) baud_cnt <= cell_end ? '0 : baud_cnt + BAUD_ONE;
      case (state)
        S_IDLE: tx <= 1'b1;
        S_START: begin
          if (cell_end) begin
            state <= S_DATA;
            tx    <= shift[0];
          end
        end
        S_DATA: begin
          if (cell_end) begin
            if (bit_cnt == BIT_LAST) begin
              if (PARITY != 0) begin
                state <= S_PARITY;
                tx    <= parity_bit;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_ONE;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end
        end
        S_PARITY: begin
          if (cell_end) begin
            state <= S_STOP;
            tx    <= 1'b1;
          end
        end
        S_STOP: begin
          if (cell_end) begin
            if (stop_cnt == STOP_LAST) state <= S_IDLE;
            else                       stop_cnt <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.serial_tx   = tx;
  assign bus.char_ready  = (level != LEVEL_FULL);
  assign bus.serial_busy = (state != S_IDLE) || (level != '0);
  assign bus.fifo_level  = level;
endmodule
`default_nettype wire
